// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU sweep sequencer: op count, the ALU control
// word for each defined operation, and the sequencer state encoding.
package alu_seq_pkg;

  localparam int NUM_OPS = 18;

  // {zx,nx,zy,ny,f,no} for ops 0..17:
  // 0, 1, -1, x, y, !x, !y, -x, -y, x+1, y+1, x-1, y-1, x+y, x-y, y-x, x&y, x|y
  localparam logic [5:0] OP_TABLE [NUM_OPS] = '{
    6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
    6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
    6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101
  };

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_OUT   = 2'd2,
    S_DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/alu_op_rom.sv
// Op index to ALU control word lookup; indices past the last op decode to 0.
module alu_op_rom
  import alu_seq_pkg::*;
(
  input  logic [4:0] op,
  output logic [5:0] ctrl
);

  always_comb begin
    ctrl = 6'b000000;
    if (op < 5'(NUM_OPS))
      ctrl = OP_TABLE[op];
  end

endmodule

// File: rtl/alu_sweep_sequencer.sv
// Walks the shared ALU through ops [op_first..op_last] x operand pairs
// [0..pair_count-1], streaming each result out over a valid/ready port.
module alu_sweep_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NUM_PAIRS = 10,
  parameter int IDX_W     = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       op_first,
  input  logic [4:0]       op_last,
  input  logic [3:0]       pair_count,
  input  logic             opnd_we,
  input  logic [3:0]       opnd_addr,
  input  logic [7:0]       opnd_x,
  input  logic [7:0]       opnd_y,
  output logic [7:0]       alu_x,
  output logic [7:0]       alu_y,
  output logic [5:0]       alu_ctrl,
  input  logic [7:0]       alu_o,
  input  logic             alu_zr,
  input  logic             alu_ng,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic             res_zr,
  output logic             res_ng,
  output logic [IDX_W-1:0] res_index,
  output logic             busy,
  output logic             done,
  output logic             err
);

  seq_state_t state;
  logic [4:0] op_idx, op_last_r;
  logic [3:0] pair_idx, pair_cnt_r;

  // Operand table is deliberately not reset; only NUM_PAIRS entries are ever written.
  logic [7:0] tab_x [16];
  logic [7:0] tab_y [16];

  logic       legal, last_pair, last_op;
  logic [3:0] next_pair, rd_sel;
  logic [4:0] next_op, rom_op;
  logic [5:0] rom_ctrl;

  assign legal = (op_first <= op_last) && (op_last < 5'(NUM_OPS)) &&
                 (pair_count != 4'd0) && ({1'b0, pair_count} <= 5'(NUM_PAIRS));

  assign last_pair = (pair_idx == 4'(pair_cnt_r - 4'd1));
  assign last_op   = (op_idx == op_last_r);
  assign next_pair = last_pair ? 4'd0 : 4'(pair_idx + 4'd1);
  assign next_op   = last_pair ? 5'(op_idx + 5'd1) : op_idx;

  // The same lookup serves the sweep launch (from IDLE) and each advance.
  assign rom_op = (state == S_IDLE) ? op_first : next_op;
  assign rd_sel = (state == S_IDLE) ? 4'd0 : next_pair;

  alu_op_rom u_rom (
    .op   (rom_op),
    .ctrl (rom_ctrl)
  );

  always_ff @(posedge clk) begin
    if (opnd_we && state == S_IDLE && {1'b0, opnd_addr} < 5'(NUM_PAIRS)) begin
      tab_x[opnd_addr] <= opnd_x;
      tab_y[opnd_addr] <= opnd_y;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      op_idx     <= '0;
      op_last_r  <= '0;
      pair_idx   <= '0;
      pair_cnt_r <= '0;
      alu_x      <= '0;
      alu_y      <= '0;
      alu_ctrl   <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_zr     <= 1'b0;
      res_ng     <= 1'b0;
      res_index  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (legal) begin
              op_idx     <= op_first;
              op_last_r  <= op_last;
              pair_idx   <= '0;
              pair_cnt_r <= pair_count;
              alu_x      <= tab_x[rd_sel];
              alu_y      <= tab_y[rd_sel];
              alu_ctrl   <= rom_ctrl;
              busy       <= 1'b1;
              state      <= S_ISSUE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          // ALU inputs have been stable for a full cycle; sample its result.
          res_data  <= alu_o;
          res_zr    <= alu_zr;
          res_ng    <= alu_ng;
          res_index <= IDX_W'(op_idx) * IDX_W'(NUM_PAIRS) + IDX_W'(pair_idx);
          res_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (last_pair && last_op) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              pair_idx <= next_pair;
              op_idx   <= next_op;
              alu_x    <= tab_x[rd_sel];
              alu_y    <= tab_y[rd_sel];
              alu_ctrl <= rom_ctrl;
              state    <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sweep_sequencer.sv
// Randomized scoreboard bench for alu_sweep_sequencer with an attached ALU model.
module tb_alu_sweep_sequencer;

  localparam int NP = 10;
  localparam int IW = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [4:0]    op_first = '0, op_last = '0;
  logic [3:0]    pair_count = '0;
  logic          opnd_we = 1'b0;
  logic [3:0]    opnd_addr = '0;
  logic [7:0]    opnd_x = '0, opnd_y = '0;
  logic [7:0]    alu_x, alu_y, alu_o;
  logic [5:0]    alu_ctrl;
  logic          alu_zr, alu_ng;
  logic          res_valid, res_ready = 1'b0;
  logic [7:0]    res_data;
  logic          res_zr, res_ng;
  logic [IW-1:0] res_index;
  logic          busy, done, err;

  alu_sweep_sequencer #(.NUM_PAIRS(NP), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .start(start), .op_first(op_first), .op_last(op_last),
    .pair_count(pair_count), .opnd_we(opnd_we), .opnd_addr(opnd_addr),
    .opnd_x(opnd_x), .opnd_y(opnd_y), .alu_x(alu_x), .alu_y(alu_y),
    .alu_ctrl(alu_ctrl), .alu_o(alu_o), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_zr(res_zr), .res_ng(res_ng), .res_index(res_index),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // The shared combinational ALU the sequencer drives.
  logic [7:0] ex, ey, eo;
  always_comb begin
    ex = alu_ctrl[5] ? 8'h00 : alu_x;
    if (alu_ctrl[4]) ex = ~ex;
    ey = alu_ctrl[3] ? 8'h00 : alu_y;
    if (alu_ctrl[2]) ey = ~ey;
    eo = alu_ctrl[1] ? 8'(ex + ey) : (ex & ey);
    if (alu_ctrl[0]) eo = ~eo;
  end
  assign alu_o  = eo;
  assign alu_zr = (eo == 8'h00);
  assign alu_ng = eo[7];

  // Reference: what each op means arithmetically.
  function automatic logic [7:0] ref_op(input int op, input logic [7:0] x, input logic [7:0] y);
    case (op)
      0:  return 8'h00;
      1:  return 8'h01;
      2:  return 8'hFF;
      3:  return x;
      4:  return y;
      5:  return ~x;
      6:  return ~y;
      7:  return 8'(8'd0 - x);
      8:  return 8'(8'd0 - y);
      9:  return 8'(x + 8'd1);
      10: return 8'(y + 8'd1);
      11: return 8'(x - 8'd1);
      12: return 8'(y - 8'd1);
      13: return 8'(x + y);
      14: return 8'(x - y);
      15: return 8'(y - x);
      16: return x & y;
      default: return x | y;
    endcase
  endfunction

  logic [5:0] CTRL [18] = '{
    6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
    6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
    6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101
  };

  typedef struct {
    logic [7:0] d;
    logic       zr, ng;
    int         idx;
    logic [5:0] ctrl;
    logic [7:0] x, y;
  } exp_t;

  exp_t q[$];
  logic [7:0] tx [16];
  logic [7:0] ty [16];
  int n_checks = 0, n_pass = 0;
  int done_cnt = 0, err_cnt = 0, res_cnt = 0;
  bit rand_ready = 1'b0, force_stall = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Consumer ready pattern, changed just after each rising edge.
  initial forever begin
    @(posedge clk); #1;
    if (force_stall)     res_ready = 1'b0;
    else if (rand_ready) res_ready = 1'($urandom_range(0, 1));
    else                 res_ready = 1'b1;
  end

  // Monitor: pop and compare on every accepted result; check hold during stalls.
  bit         stalled = 1'b0;
  logic [7:0] hold_d;
  logic [IW-1:0] hold_i;
  always @(negedge clk) begin
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (err)  err_cnt++;
      if (res_valid) begin
        if (stalled) begin
          check("stall_data", res_data, hold_d);
          check("stall_index", res_index, hold_i);
        end
        if (res_ready) begin
          stalled = 1'b0;
          res_cnt++;
          if (q.size() == 0) begin
            check("unexpected_result", res_index, 32'hFFFF_FFFF);
          end else begin
            exp_t e;
            e = q.pop_front();
            check("res_index", res_index, e.idx);
            check("res_data", res_data, e.d);
            check("res_zr", res_zr, e.zr);
            check("res_ng", res_ng, e.ng);
            check("alu_ctrl", alu_ctrl, e.ctrl);
            check("alu_xy", {alu_x, alu_y}, {e.x, e.y});
          end
        end else begin
          stalled = 1'b1;
          hold_d  = res_data;
          hold_i  = res_index;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic wr(input int a, input logic [7:0] x, input logic [7:0] y);
    @(posedge clk); #1;
    opnd_we = 1'b1; opnd_addr = 4'(a); opnd_x = x; opnd_y = y;
    @(posedge clk); #1;
    opnd_we = 1'b0;
    if (a < NP) begin tx[a] = x; ty[a] = y; end
  endtask

  task automatic run_sweep(input int opf, input int opl, input int pc, input bit rnd, input bit poke);
    int total;
    total = (opl - opf + 1) * pc;
    rand_ready = rnd; done_cnt = 0; err_cnt = 0; res_cnt = 0;
    for (int op = opf; op <= opl; op++)
      for (int p = 0; p < pc; p++) begin
        exp_t e;
        e.d = ref_op(op, tx[p], ty[p]);
        e.zr = (e.d == 8'h00); e.ng = e.d[7];
        e.idx = op * NP + p; e.ctrl = CTRL[op]; e.x = tx[p]; e.y = ty[p];
        q.push_back(e);
      end
    @(posedge clk); #1;
    op_first = 5'(opf); op_last = 5'(opl); pair_count = 4'(pc); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (poke && c == 3) begin
        // Table write and restart attempt while busy must both be ignored.
        opnd_we = 1'b1; opnd_addr = 4'd0; opnd_x = ~tx[0]; opnd_y = 8'h5A;
        start = 1'b1; op_first = 5'd0; op_last = 5'd0; pair_count = 4'd1;
      end else begin
        opnd_we = 1'b0; start = 1'b0;
      end
      @(posedge clk); #1;
      if (done_cnt != 0 && q.size() == 0) break;
    end
    opnd_we = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("result_count", res_cnt, total);
    check("queue_drained", q.size(), 0);
    check("no_err_in_sweep", err_cnt, 0);
    check("busy_after", busy, 1'b0);
    q.delete();
  endtask

  task automatic bad_start(input int opf, input int opl, input int pc);
    @(posedge clk); #1;
    op_first = 5'(opf); op_last = 5'(opl); pair_count = 4'(pc); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("err_pulse", err, 1'b1);
    check("err_busy", busy, 1'b0);
    check("err_no_valid", res_valid, 1'b0);
    @(negedge clk);
    check("err_one_cycle", err, 1'b0);
    check("err_still_idle", busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) begin tx[i] = 8'h00; ty[i] = 8'h00; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", res_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done_err", {done, err}, 2'b00);
    check("rst_alu", {alu_x, alu_y, alu_ctrl}, 22'h0);
    check("rst_res", {res_data, res_zr, res_ng, res_index}, '0);
    @(posedge clk); #1;
    reset = 1'b0;

    wr(0, 8'hFF, 8'hCF);
    wr(1, 8'h76, 8'h2A);
    wr(2, 8'hE7, 8'hD5);
    run_sweep(0, 2, 1, 1'b0, 1'b0);
    run_sweep(13, 13, 2, 1'b0, 1'b0);
    run_sweep(16, 16, 3, 1'b1, 1'b0);

    bad_start(5, 3, 1);
    bad_start(0, 0, 0);
    bad_start(0, 17, 11);
    bad_start(18, 18, 1);

    for (int i = 0; i < NP; i++) wr(i, 8'($urandom), 8'($urandom));
    wr(12, 8'hAA, 8'h55);
    run_sweep(0, 17, NP, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      int f, l, p;
      f = $urandom_range(0, 17);
      l = $urandom_range(f, 17);
      p = $urandom_range(1, NP);
      run_sweep(f, l, p, 1'b1, 1'b0);
    end

    // Abort a sweep while a result is held in the output stage.
    force_stall = 1'b1;
    @(posedge clk); #1;
    op_first = 5'd0; op_last = 5'd17; pair_count = 4'(NP); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (res_valid) begin seen = 1'b1; break; end
      end
      check("reached_out", seen, 1'b1);
    end
    @(posedge clk); #1;
    reset = 1'b1; done_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    check("abort_valid", res_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0; force_stall = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    run_sweep(3, 5, 2, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_sweep_sequencer.md
Name: alu_sweep_sequencer

Overview:
Controller that sequences the shared 8-bit combinational ALU (control bits zx,nx,zy,ny,f,no; outputs o,zr,ng) through a programmable range of its 18 defined operations over a loadable table of operand pairs. For each (op, pair) it drives the ALU, samples the result and streams it out with a valid/ready handshake, tagged with a linear result index. It replaces free-running bench sweeps with a reusable on-chip self-test and characterisation engine.

Parameters:
NUM_PAIRS, 10, depth of operand table (1..15)
IDX_W, 9, width of res_index (must hold 18*NUM_PAIRS-1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request a sweep (sampled only in IDLE)
op_first  in  5  first op index (0..17)
op_last  in  5  last op index (0..17, >= op_first)
pair_count  in  4  pairs per op (1..NUM_PAIRS)
opnd_we  in  1  operand table write strobe
opnd_addr  in  4  operand table entry
opnd_x  in  8  x operand to store
opnd_y  in  8  y operand to store
alu_x  out  8  registered x to ALU
alu_y  out  8  registered y to ALU
alu_ctrl  out  6  registered {zx,nx,zy,ny,f,no}
alu_o  in  8  ALU result
alu_zr  in  1  ALU zero flag
alu_ng  in  1  ALU negative flag
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  8  captured alu_o
res_zr  out  1  captured alu_zr
res_ng  out  1  captured alu_ng
res_index  out  IDX_W  op_idx*NUM_PAIRS + pair_idx
busy  out  1  sweep in progress
done  out  1  one-cycle pulse after final result accepted
err  out  1  one-cycle pulse on rejected start

Behaviour:
- Reset: all outputs 0; FSM in IDLE; op_idx/pair_idx 0. Operand table contents are not reset.
- States: IDLE, ISSUE, OUT, DONE.
- IDLE: start=1 with legal args (op_first<=op_last<=17, 1<=pair_count<=NUM_PAIRS) -> load op_idx=op_first, pair_idx=0, register alu_x/alu_y from table[0], alu_ctrl=OP_TABLE[op_first]; busy=1; go ISSUE. Illegal args -> err=1 next cycle, stay IDLE, busy stays 0.
- ISSUE (1 cycle): ALU settles; at end, capture alu_o/zr/ng into res_*, res_index computed; res_valid=1; go OUT. First res_valid 2 cycles after start sampled.
- OUT: res_* and res_valid held stable while res_ready=0. On res_valid&&res_ready: if pair_idx==pair_count-1 and op_idx==op_last -> res_valid=0, go DONE; else advance (pair inner loop; pair wrap to 0 increments op_idx), reload alu_* regs, res_valid=0, go ISSUE. Peak throughput: 1 result / 2 cycles.
- DONE: done=1 for exactly one cycle, busy=0, back to IDLE; start in DONE cycle ignored.
- start while busy: ignored, no err.
- opnd_we while busy: ignored (table frozen during sweep); in IDLE writes table[opnd_addr]; addr>=NUM_PAIRS ignored.
- Reset mid-sweep: immediate return to IDLE next edge, res_valid/busy drop, no done.
- res_index width: op_idx*NUM_PAIRS+pair_idx, unsigned, max 179 for defaults.

Decomposition:
- Package alu_seq_pkg: NUM_OPS=18, 6-bit ctrl constants OP_TABLE[0..17] = 101010,111111,111010,001100,110000,001101,110001,001111,110011,011111,110111,001110,110010,000010,010011,000111,000000,010101; FSM state encoding.
- Sub-module alu_op_rom: 5-bit op index -> 6-bit ctrl (combinational, out-of-range -> 000000).

Test Plan:
- Table[0]={FF,CF}, op 0..2, pair_count=1, res_ready=1 -> results 00(zr=1,ng=0) idx0, 01 idx10, FF(ng=1) idx20; done one pulse.
- Table[1]={76,2A}, op 13..13, pair_count=2 -> idx131 res_data=A0, ng=1, zr=0; alu_ctrl=000010 during ISSUE.
- Table[2]={E7,D5}, op 16 (x&y), pair_count=3 -> idx162 res_data=C5, ng=1.
- Full sweep op 0..17, pair_count=10, random res_ready -> exactly 180 results, indices 0..179 in order, data stable while stalled, done once.
- start with op_first=5, op_last=3 (and pair_count=0) -> err pulse, busy=0, no res_valid.
- reset asserted in OUT mid-sweep -> next cycle res_valid=0, busy=0, no done; new start runs normally from op_first.
